// File: rtl/spi_reg_pkg.sv
// Shared constants and address-split helpers for the SPI register bank.
package spi_reg_pkg;
   localparam int SPI_BYTE_W = 8;
   localparam logic [SPI_BYTE_W-1:0] DEFAULT_UNMAPPED_VAL = 8'h99;

   // Width of an index over n items, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int byte_sel_w(input int reg_bytes);
      return idx_w(reg_bytes);
   endfunction

   function automatic int unsigned addr_reg(input int unsigned addr, input int reg_bytes);
      return addr >> $clog2(reg_bytes);
   endfunction

   function automatic int unsigned addr_byte(input int unsigned addr, input int reg_bytes);
      return addr & unsigned'(reg_bytes - 1);
   endfunction
endpackage

// File: rtl/spi_reg_bank_if.sv
// Byte-level bus between the SPI shifter (master) and the register bank (slave).
interface spi_reg_bank_if
   import spi_reg_pkg::*;
#(
   parameter int ADDR_W = 7
);
   logic                  cs_active;
   logic                  bus_wr_stb;
   logic                  bus_rd_stb;
   logic [ADDR_W-1:0]     bus_addr;
   logic [SPI_BYTE_W-1:0] bus_wdata;
   logic [SPI_BYTE_W-1:0] bus_rdata;

   modport master (
      output cs_active, bus_wr_stb, bus_rd_stb, bus_addr, bus_wdata,
      input  bus_rdata
   );

   modport slave (
      input  cs_active, bus_wr_stb, bus_rd_stb, bus_addr, bus_wdata,
      output bus_rdata
   );
endinterface

// File: rtl/spi_burst_addr.sv
// Burst address tracker: first-strobe flag, auto-increment pointer with wrap,
// and split of the effective byte address into register/byte/mapped.
module spi_burst_addr
   import spi_reg_pkg::*;
#(
   parameter int NUM_REGS  = 16,
   parameter int REG_BYTES = 2,
   parameter int ADDR_W    = 7,
   localparam int REG_W    = idx_w(NUM_REGS),
   localparam int BSEL_W   = byte_sel_w(REG_BYTES)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cs_active,
   input  logic              stb,
   input  logic [ADDR_W-1:0] bus_addr,
   output logic [REG_W-1:0]  reg_idx,
   output logic [BSEL_W-1:0] byte_idx,
   output logic              mapped
);
   localparam int NUM_BYTES = NUM_REGS * REG_BYTES;

   logic              first;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] eff_addr;

   // NOTE: every output is assigned on every path through always_comb, so no latch is inferred.
   always_comb begin
      if (first || !cs_active) begin
         eff_addr = bus_addr;
      end else if (ptr == ADDR_W'(NUM_BYTES - 1)) begin
         eff_addr = '0;
      end else begin
         eff_addr = ptr + 1'b1;
      end
      mapped   = 32'(eff_addr) < 32'(NUM_BYTES);
      reg_idx  = REG_W'(addr_reg(32'(eff_addr), REG_BYTES));
      byte_idx = BSEL_W'(addr_byte(32'(eff_addr), REG_BYTES));
   end

   // NOTE: state is updated with non-blocking assignments only, so readers in the same edge see old values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr   <= '0;
         first <= 1'b1;
      end else if (stb) begin
         ptr   <= eff_addr;
         first <= !cs_active;
      end else if (!cs_active) begin
         first <= 1'b1;
      end
   end
endmodule

// File: rtl/spi_reg_bank.sv
// Parametrised SPI register bank: tear-free multi-byte writes via a staging
// buffer, tear-free multi-byte reads via a snapshot, read-only sourcing, sticky error.
module spi_reg_bank
   import spi_reg_pkg::*;
#(
   parameter int NUM_REGS  = 16,
   parameter int REG_BYTES = 2,
   parameter int ADDR_W    = 7,
   parameter logic [NUM_REGS-1:0] RO_MASK = '0,
   parameter logic [NUM_REGS*REG_BYTES*SPI_BYTE_W-1:0] RESET_VAL = '0,
   parameter logic [SPI_BYTE_W-1:0] UNMAPPED_VAL = DEFAULT_UNMAPPED_VAL
) (
   input  logic                                    clk,
   input  logic                                    reset_n,
   spi_reg_bank_if.slave                           bus,
   output logic [NUM_REGS*REG_BYTES*SPI_BYTE_W-1:0] reg_q,
   output logic [NUM_REGS-1:0]                     reg_upd_stb,
   input  logic [NUM_REGS*REG_BYTES*SPI_BYTE_W-1:0] ro_in,
   output logic [NUM_REGS-1:0]                     ro_rd_stb,
   input  logic                                    err_clr,
   output logic                                    access_err
);
   localparam int REG_W  = idx_w(NUM_REGS);
   localparam int BSEL_W = byte_sel_w(REG_BYTES);
   localparam int RW     = REG_BYTES * SPI_BYTE_W;
   localparam logic [BSEL_W-1:0] TOP_BYTE = BSEL_W'(REG_BYTES - 1);

   typedef logic [REG_BYTES-1:0][SPI_BYTE_W-1:0] word_t;

   word_t                 regs     [NUM_REGS];
   word_t                 ro_words [NUM_REGS];
   word_t                 stg_data;
   logic [REG_BYTES-1:0]  stg_vld;
   logic [REG_W-1:0]      stg_tag;
   word_t                 snap_data;
   logic                  snap_vld;
   logic [REG_W-1:0]      snap_tag;
   logic [SPI_BYTE_W-1:0] rdata;

   logic                  stb;
   logic [REG_W-1:0]      reg_idx;
   logic [BSEL_W-1:0]     byte_idx;
   logic                  mapped;

   logic                  wr;
   logic                  rd;
   logic                  is_ro;
   logic                  err_set;
   word_t                 live_word;
   word_t                 commit_word;

   assign stb           = bus.bus_wr_stb | bus.bus_rd_stb;
   assign bus.bus_rdata = rdata;

   spi_burst_addr #(
      .NUM_REGS  (NUM_REGS),
      .REG_BYTES (REG_BYTES),
      .ADDR_W    (ADDR_W)
   ) u_burst_addr (
      .clk       (clk),
      .reset_n   (reset_n),
      .cs_active (bus.cs_active),
      .stb       (stb),
      .bus_addr  (bus.bus_addr),
      .reg_idx   (reg_idx),
      .byte_idx  (byte_idx),
      .mapped    (mapped)
   );

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
      assign reg_q[i*RW +: RW] = regs[i];
      assign ro_words[i]       = ro_in[i*RW +: RW];
   end

   // A simultaneous read is dropped in favour of the write.
   always_comb begin
      wr        = bus.bus_wr_stb;
      rd        = bus.bus_rd_stb & ~bus.bus_wr_stb;
      is_ro     = mapped & RO_MASK[reg_idx];
      live_word = is_ro ? ro_words[reg_idx] : regs[reg_idx];

      commit_word = regs[reg_idx];
      for (int k = 0; k < REG_BYTES; k++) begin
         if (stg_vld[k] && (stg_tag == reg_idx)) begin
            commit_word[k] = stg_data[k];
         end
      end
      commit_word[TOP_BYTE] = bus.bus_wdata;

      err_set = (wr & bus.bus_rd_stb) | (wr & (~mapped | is_ro)) | (rd & ~mapped);
   end

   // NOTE: the register array is flops with reset (not a RAM) because RESET_VAL must load on reset_n.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= RESET_VAL[i*RW +: RW];
         end
         stg_data    <= '0;
         stg_vld     <= '0;
         stg_tag     <= '0;
         snap_data   <= '0;
         snap_vld    <= 1'b0;
         snap_tag    <= '0;
         rdata       <= '0;
         reg_upd_stb <= '0;
         ro_rd_stb   <= '0;
         access_err  <= 1'b0;
      end else begin
         reg_upd_stb <= '0;
         ro_rd_stb   <= '0;

         if (wr && mapped && !is_ro) begin
            if (byte_idx == TOP_BYTE) begin
               regs[reg_idx]        <= commit_word;
               reg_upd_stb[reg_idx] <= 1'b1;
               stg_vld              <= '0;
               snap_vld             <= 1'b0;
            end else if (stg_tag == reg_idx) begin
               stg_vld[byte_idx]  <= 1'b1;
               stg_data[byte_idx] <= bus.bus_wdata;
            end else begin
               // Retag: stale bytes of another register are discarded.
               stg_vld            <= '0;
               stg_vld[byte_idx]  <= 1'b1;
               stg_tag            <= reg_idx;
               stg_data[byte_idx] <= bus.bus_wdata;
            end
         end

         if (rd) begin
            if (!mapped) begin
               rdata <= UNMAPPED_VAL;
            end else if (byte_idx == '0) begin
               snap_data <= live_word;
               snap_vld  <= 1'b1;
               snap_tag  <= reg_idx;
               rdata     <= live_word[0];
               if (is_ro) begin
                  ro_rd_stb[reg_idx] <= 1'b1;
               end
            end else if (snap_vld && (snap_tag == reg_idx)) begin
               rdata <= snap_data[byte_idx];
            end else begin
               rdata <= live_word[byte_idx];
            end
         end

         if (err_set) begin
            access_err <= 1'b1;
         end else if (err_clr) begin
            access_err <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed literal checks plus random
// traffic compared every cycle against a byte-level behavioural model.
module tb_spi_reg_bank;
   import spi_reg_pkg::*;

   localparam int NR = 16;
   localparam int RB = 2;
   localparam int AW = 7;
   localparam int NB = NR * RB;
   localparam int WB = NR * RB * 8;
   localparam logic [NR-1:0] RO_MASK_P = 16'h0104;
   localparam logic [7:0] UNMAP_P = 8'h99;

   function automatic logic [WB-1:0] make_reset();
      logic [WB-1:0] v;
      v = '0;
      for (int i = 0; i < NR; i++) v[i*16 +: 16] = {8'(8'hA0 + i), 8'(8'h50 + i)};
      return v;
   endfunction

   localparam logic [WB-1:0] RST_VAL = make_reset();

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          err_clr = 1'b0;
   logic [WB-1:0] reg_q;
   logic [NR-1:0] reg_upd_stb;
   logic [WB-1:0] ro_in_v = '0;
   logic [NR-1:0] ro_rd_stb;
   logic          access_err;
   logic          check_en = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   spi_reg_bank_if #(.ADDR_W(AW)) bus_if ();

   spi_reg_bank #(
      .NUM_REGS     (NR),
      .REG_BYTES    (RB),
      .ADDR_W       (AW),
      .RO_MASK      (RO_MASK_P),
      .RESET_VAL    (RST_VAL),
      .UNMAPPED_VAL (UNMAP_P)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus_if),
      .reg_q       (reg_q),
      .reg_upd_stb (reg_upd_stb),
      .ro_in       (ro_in_v),
      .ro_rd_stb   (ro_rd_stb),
      .err_clr     (err_clr),
      .access_err  (access_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (byte addresses, plain ints) ----------------
   int unsigned   m_reg [NR];
   bit            m_first;
   int            m_ptr;
   int            m_stg_tag;
   bit [RB-1:0]   m_stg_vld;
   int unsigned   m_stg [RB];
   bit            m_snap_vld;
   int            m_snap_tag;
   int unsigned   m_snap;
   logic [7:0]    e_rdata;
   logic [NR-1:0] e_upd;
   logic [NR-1:0] e_ro;
   logic          e_err;
   logic [WB-1:0] exp_flat;

   function automatic int unsigned byte_of(input int unsigned w, input int k);
      return (w >> (8 * k)) & 32'hFF;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_reg[i] = 32'(RST_VAL[i*16 +: 16]);
      m_first    = 1'b1;
      m_ptr      = 0;
      m_stg_tag  = -1;
      m_stg_vld  = '0;
      m_snap_vld = 1'b0;
      m_snap_tag = -1;
      m_snap     = 0;
      e_rdata    = '0;
      e_upd      = '0;
      e_ro       = '0;
      e_err      = 1'b0;
   endtask

   task automatic model_step();
      bit cs, wr, rd, err_set, mapped, ro;
      int addr, r, b;
      int unsigned w, src, wdata;
      cs      = bus_if.cs_active;
      wr      = bus_if.bus_wr_stb;
      rd      = bus_if.bus_rd_stb && !wr;
      wdata   = 32'(bus_if.bus_wdata);
      err_set = wr && bus_if.bus_rd_stb;
      e_upd   = '0;
      e_ro    = '0;
      if (wr || rd) begin
         if (m_first || !cs)      addr = int'(bus_if.bus_addr);
         else if (m_ptr == NB - 1) addr = 0;
         else                     addr = (m_ptr + 1) % (1 << AW);
         m_ptr   = addr;
         m_first = !cs;
         mapped  = addr < NB;
         r       = addr / RB;
         b       = addr % RB;
         ro      = 1'b0;
         if (mapped) ro = RO_MASK_P[r];
         if (wr) begin
            if (!mapped || ro) begin
               err_set = 1'b1;
            end else if (b == RB - 1) begin
               w = 0;
               for (int k = 0; k < RB - 1; k++) begin
                  if (m_stg_tag == r && m_stg_vld[k]) w |= m_stg[k] << (8 * k);
                  else                                w |= byte_of(m_reg[r], k) << (8 * k);
               end
               w |= wdata << (8 * (RB - 1));
               m_reg[r]   = w;
               e_upd[r]   = 1'b1;
               m_stg_vld  = '0;
               m_snap_vld = 1'b0;
            end else begin
               if (m_stg_tag != r) begin
                  m_stg_vld = '0;
                  m_stg_tag = r;
               end
               m_stg[b]     = wdata;
               m_stg_vld[b] = 1'b1;
            end
         end else begin
            if (!mapped) begin
               e_rdata = UNMAP_P;
               err_set = 1'b1;
            end else begin
               src = ro ? 32'(ro_in_v[r*16 +: 16]) : m_reg[r];
               if (b == 0) begin
                  m_snap     = src;
                  m_snap_vld = 1'b1;
                  m_snap_tag = r;
                  e_rdata    = 8'(byte_of(src, 0));
                  if (ro) e_ro[r] = 1'b1;
               end else if (m_snap_vld && m_snap_tag == r) begin
                  e_rdata = 8'(byte_of(m_snap, b));
               end else begin
                  e_rdata = 8'(byte_of(src, b));
               end
            end
         end
      end else if (!cs) begin
         m_first = 1'b1;
      end
      if (err_set)      e_err = 1'b1;
      else if (err_clr) e_err = 1'b0;
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) model_reset();
      else          model_step();
   end

   // One compare process: every output, every cycle, on the inactive edge.
   always @(negedge clk) begin
      if (check_en) begin
         for (int i = 0; i < NR; i++) exp_flat[i*16 +: 16] = 16'(m_reg[i]);
         check("reg_q", reg_q, exp_flat);
         check("reg_upd_stb", WB'(reg_upd_stb), WB'(e_upd));
         check("ro_rd_stb", WB'(ro_rd_stb), WB'(e_ro));
         check("access_err", WB'(access_err), WB'(e_err));
         check("bus_rdata", WB'(bus_if.bus_rdata), WB'(e_rdata));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic op(input bit cs, input bit wr, input bit rd, input int addr,
                     input int data, input bit clr);
      bus_if.cs_active  = cs;
      bus_if.bus_wr_stb = wr;
      bus_if.bus_rd_stb = rd;
      bus_if.bus_addr   = AW'(addr);
      bus_if.bus_wdata  = 8'(data);
      err_clr           = clr;
      @(posedge clk);
      #1;
      bus_if.bus_wr_stb = 1'b0;
      bus_if.bus_rd_stb = 1'b0;
      err_clr           = 1'b0;
   endtask

   task automatic idle(input int n, input bit cs, input bit clr);
      bus_if.cs_active  = cs;
      bus_if.bus_wr_stb = 1'b0;
      bus_if.bus_rd_stb = 1'b0;
      err_clr           = clr;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      err_clr = 1'b0;
   endtask

   function automatic logic [15:0] word_q(input int i);
      return reg_q[i*16 +: 16];
   endfunction

   initial begin
      bit cs_r, wr_r, rd_r, clr_r;
      int kind, addr_r, data_r;

      bus_if.cs_active  = 1'b0;
      bus_if.bus_wr_stb = 1'b0;
      bus_if.bus_rd_stb = 1'b0;
      bus_if.bus_addr   = '0;
      bus_if.bus_wdata  = '0;
      model_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_en = 1'b1;
      check("reset_reg_q", reg_q, RST_VAL);
      check("reset_err", WB'(access_err), '0);
      reset_n = 1'b1;
      idle(2, 1'b0, 1'b0);

      // Two-byte write: nothing visible until the top byte commits.
      op(1'b1, 1'b1, 1'b0, 8'h08, 8'h34, 1'b0);
      check("t1_after_low", WB'(word_q(4)), WB'(16'hA454));
      check("t1_no_upd", WB'(reg_upd_stb), '0);
      op(1'b1, 1'b1, 1'b0, 8'h55, 8'h12, 1'b0);
      check("t1_commit", WB'(word_q(4)), WB'(16'h1234));
      check("t1_upd_pulse", WB'(reg_upd_stb), WB'(16'h0010));
      idle(1, 1'b0, 1'b0);
      check("t1_upd_single", WB'(reg_upd_stb), '0);

      // Burst with wrap; bus_addr after the first strobe is ignored.
      op(1'b1, 1'b1, 1'b0, 8'h1E, 8'hAA, 1'b0);
      op(1'b1, 1'b1, 1'b0, 8'h03, 8'hBB, 1'b0);
      check("t2_reg15", WB'(word_q(15)), WB'(16'hBBAA));
      op(1'b1, 1'b1, 1'b0, 8'h40, 8'hCC, 1'b0);
      op(1'b1, 1'b1, 1'b0, 8'h11, 8'hDD, 1'b0);
      check("t2_reg0_wrap", WB'(word_q(0)), WB'(16'hDDCC));
      idle(1, 1'b0, 1'b0);

      // Read-only snapshot: the high byte comes from the byte-0 snapshot.
      ro_in_v[2*16 +: 16] = 16'h5678;
      op(1'b1, 1'b0, 1'b1, 8'h04, 0, 1'b0);
      check("t3_lo", WB'(bus_if.bus_rdata), WB'(8'h78));
      check("t3_pop", WB'(ro_rd_stb), WB'(16'h0004));
      ro_in_v[2*16 +: 16] = 16'h9999;
      op(1'b1, 1'b0, 1'b1, 8'h33, 0, 1'b0);
      check("t3_hi", WB'(bus_if.bus_rdata), WB'(8'h56));
      check("t3_pop_once", WB'(ro_rd_stb), '0);
      idle(1, 1'b0, 1'b0);

      // Errors: write to read-only, read of unmapped, clear.
      op(1'b0, 1'b1, 1'b0, 8'h04, 8'h01, 1'b0);
      check("t4_ro_kept", WB'(word_q(2)), WB'(16'hA252));
      check("t4_err_set", WB'(access_err), WB'(1'b1));
      idle(1, 1'b0, 1'b1);
      check("t4_err_clr", WB'(access_err), '0);
      op(1'b0, 1'b0, 1'b1, 8'h7F, 0, 1'b0);
      check("t4_unmapped", WB'(bus_if.bus_rdata), WB'(8'h99));
      check("t4_err_unmapped", WB'(access_err), WB'(1'b1));
      idle(1, 1'b0, 1'b1);

      // Stale staging of reg3 is discarded by the retag to reg5.
      op(1'b0, 1'b1, 1'b0, 8'h06, 8'h11, 1'b0);
      op(1'b0, 1'b1, 1'b0, 8'h0A, 8'h22, 1'b0);
      op(1'b0, 1'b1, 1'b0, 8'h07, 8'h33, 1'b0);
      check("t5_reg3", WB'(word_q(3)), WB'(16'h3353));
      check("t5_reg5_kept", WB'(word_q(5)), WB'(16'hA555));
      check("t5_upd3", WB'(reg_upd_stb), WB'(16'h0008));

      // Reset between the two bytes of a write.
      op(1'b0, 1'b1, 1'b0, 8'h0C, 8'h77, 1'b0);
      reset_n = 1'b0;
      #1;
      check("t6_async_reset", reg_q, RST_VAL);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      op(1'b0, 1'b1, 1'b0, 8'h0D, 8'h88, 1'b0);
      check("t6_live_low", WB'(word_q(6)), WB'(16'h8856));

      // Random traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         if (n == 700) begin
            reset_n = 1'b0;
            idle(2, 1'b0, 1'b0);
            reset_n = 1'b1;
         end
         if ($urandom_range(0, 15) == 0) begin
            for (int j = 0; j < WB / 32; j++) ro_in_v[j*32 +: 32] = $urandom;
         end
         cs_r   = ($urandom_range(0, 9) != 0);
         kind   = $urandom_range(0, 99);
         addr_r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127) : $urandom_range(0, NB - 1);
         data_r = $urandom_range(0, 255);
         clr_r  = ($urandom_range(0, 9) == 0);
         wr_r   = (kind < 45) || (kind >= 95);
         rd_r   = (kind >= 45 && kind < 90) || (kind >= 95);
         op(cs_r, wr_r, rd_r, addr_r, data_r, clr_r);
      end
      idle(3, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
